// File: rtl/xc_malu_pkg.sv
//------------------------------------------------------------------------------
// xc_malu_pkg
//------------------------------------------------------------------------------
// Shared definitions for the MALU sequencer: the sequencer state encoding,
// default iteration-counter sizing and the error result that is returned
// when an operation times out.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package xc_malu_pkg;

  // Sequencer state encoding (2 bits)
  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_RUN  = 2'd1;
  localparam logic [1:0] SEQ_DONE = 2'd2;

  // Iteration counter defaults
  localparam int XC_COUNT_W   = 6;
  localparam int XC_MAX_COUNT = 63;

  // Result reported when an operation is abandoned by the timeout
  localparam logic [63:0] XC_ERR_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = SEQ_IDLE,
    ST_RUN  = SEQ_RUN,
    ST_DONE = SEQ_DONE
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/xc_malu_seq.sv
//------------------------------------------------------------------------------
// xc_malu_seq
//------------------------------------------------------------------------------
// Sequencer for the multi-cycle MALU datapath (mul/div/rem/pmul/clmul).
// Owns the iteration registers (count, acc, arg_0, arg_1), presents them to
// the combinational datapath and reloads them with the datapath's next-state
// values every RUN cycle. When the datapath signals completion the 64-bit
// result is captured and a one-cycle ready pulse is returned to the core.
//
// Ports:
//   clock, resetn          clock and asynchronous active-low reset
//   flush                  abandon any in-flight operation
//   valid, rs1, rs2        core request and operands (rs2 is consumed by the
//                          datapath directly, not by the sequencer)
//   ready, result          one-cycle completion pulse, held 64-bit result
//   busy, dp_valid         busy in RUN/DONE, datapath valid in RUN
//   count, acc, arg_0/1    iteration registers fed to the datapath
//   dp_n_acc, dp_n_arg_0/1 datapath next-state values
//   dp_result, dp_ready    datapath result and completion flag
//   timeout                sticky timeout flag (optional feature only)
//
// Optional feature macro: XC_MALU_SEQ_TIMEOUT_EN
//   When defined, an operation still running with count saturated at
//   MAX_COUNT is terminated with an all-ones result and the timeout flag set.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module xc_malu_seq
  import xc_malu_pkg::*;
#(
  parameter int COUNT_W   = XC_COUNT_W,
  parameter int MAX_COUNT = XC_MAX_COUNT
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               flush,
  input  logic               valid,
  input  logic [31:0]        rs1,
  input  logic [31:0]        rs2,
  output logic               ready,
  output logic [63:0]        result,
  output logic               busy,
  output logic               dp_valid,
  output logic [COUNT_W-1:0] count,
  output logic [63:0]        acc,
  output logic [31:0]        arg_0,
  output logic [31:0]        arg_1,
  input  logic [63:0]        dp_n_acc,
  input  logic [31:0]        dp_n_arg_0,
  input  logic [31:0]        dp_n_arg_1,
  input  logic [63:0]        dp_result,
  input  logic               dp_ready
`ifdef XC_MALU_SEQ_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam logic [COUNT_W-1:0] c_MAX = COUNT_W'(MAX_COUNT);

  seq_state_t         r_state, w_state_nxt;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  logic [63:0]        r_acc,   w_acc_nxt;
  logic [31:0]        r_arg_0, w_arg_0_nxt;
  logic [31:0]        r_arg_1, w_arg_1_nxt;
  logic [63:0]        r_result, w_result_nxt;
  logic [COUNT_W-1:0] w_count_inc;

  // rs2 is routed to the datapath by the core; the sequencer never needs it.
  logic w_unused;
  assign w_unused = ^rs2;

  // Counter saturates rather than wraps so a long-running op cannot alias
  // back onto an early iteration index.
  assign w_count_inc = (r_count == c_MAX) ? r_count : r_count + 1'b1;

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  logic r_timeout, w_timeout_nxt;
`endif

  //----------------------------------------------------------------------------
  // State register
  //----------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // Iteration / result registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_arg_0  <= '0;
      r_arg_1  <= '0;
      r_result <= '0;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_count  <= w_count_nxt;
      r_acc    <= w_acc_nxt;
      r_arg_0  <= w_arg_0_nxt;
      r_arg_1  <= w_arg_1_nxt;
      r_result <= w_result_nxt;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  //----------------------------------------------------------------------------
  // Next-state and register-update decode
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_acc_nxt    = r_acc;
    w_arg_0_nxt  = r_arg_0;
    w_arg_1_nxt  = r_arg_1;
    w_result_nxt = r_result;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
    w_timeout_nxt = r_timeout;
`endif

    case (r_state)
      ST_IDLE: begin
        // flush has priority over a new request
        if (valid && !flush) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = '0;
          w_acc_nxt   = '0;
          w_arg_0_nxt = rs1;
          w_arg_1_nxt = '0;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
          w_timeout_nxt = 1'b0;
`endif
        end
      end

      ST_RUN: begin
        if (flush || !valid) begin
          // Abandon: registers and result are left exactly as they are.
          w_state_nxt = ST_IDLE;
        end else if (dp_ready) begin
          // dp_ready is decoded from the current count, so the iteration
          // registers must not advance on the completing cycle.
          w_state_nxt  = ST_DONE;
          w_result_nxt = dp_result;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
        end else if (r_count == c_MAX) begin
          w_state_nxt   = ST_DONE;
          w_result_nxt  = XC_ERR_RESULT;
          w_timeout_nxt = 1'b1;
`endif
        end else begin
          w_acc_nxt   = dp_n_acc;
          w_arg_0_nxt = dp_n_arg_0;
          w_arg_1_nxt = dp_n_arg_1;
          w_count_nxt = w_count_inc;
        end
      end

      ST_DONE: begin
        // Unconditional: the ready pulse is already committed this cycle.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Outputs: handshake flags decoded straight from the state register
  //----------------------------------------------------------------------------
  assign ready    = (r_state == ST_DONE);
  assign busy     = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign dp_valid = (r_state == ST_RUN);
  assign count    = r_count;
  assign acc      = r_acc;
  assign arg_0    = r_arg_0;
  assign arg_1    = r_arg_1;
  assign result   = r_result;
`ifdef XC_MALU_SEQ_TIMEOUT_EN
  assign timeout  = r_timeout;
`endif

endmodule

`default_nettype wire

// File: doc/xc_malu_seq.md
Name: xc_malu_seq

Overview:
- Sequencer for the multi-cycle MALU datapath (mul/div/rem/pmul/clmul).
- Owns the iteration state registers `count`, `acc`, `arg_0` and `arg_1`, and feeds them to the combinational muldivrem datapath.
- Each cycle it loads the datapath's next-state values back into those registers, and captures the 64-bit result once the datapath flags completion.
- Sits between the core's valid/ready instruction handshake and the datapath; also handles flush and abort.

Parameters:
- COUNT_W, 6: width of the iteration counter.
- MAX_COUNT, 63: last legal count value; used for saturation and the optional timeout.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  abandon any in-flight operation
- valid  in  1  core request; held high with stable rs1/rs2 until ready or flush
- rs1  in  32  operand 1
- rs2  in  32  operand 2
- ready  out  1  one-cycle pulse: result valid
- result  out  64  captured result; held until the next accept
- busy  out  1  high in RUN or DONE
- dp_valid  out  1  high in RUN; drives datapath valid
- count  out  COUNT_W  current iteration count
- acc  out  64  accumulator register
- arg_0  out  32  arg 0 register
- arg_1  out  32  arg 1 register
- dp_n_acc  in  64  datapath next accumulator
- dp_n_arg_0  in  32  datapath next arg 0
- dp_n_arg_1  in  32  datapath next arg 1
- dp_result  in  64  datapath result
- dp_ready  in  1  datapath done, combinational on current count
- timeout  out  1  (only with the optional feature) sticky error flag

Behaviour:
- Clocking and reset: one clock `clock`; reset `resetn` is asynchronous, active-low.
- Reset values:
  - state = IDLE
  - count = 0, acc = 0, arg_0 = 0, arg_1 = 0
  - result = 0, ready = 0, busy = 0, dp_valid = 0, timeout = 0
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - If valid && !flush: load count = 0, acc = 0, arg_0 = rs1, arg_1 = 0, then go to RUN.
  - Otherwise hold all registers.
- RUN:
  - If flush || !valid: go to IDLE. Registers are not updated; no ready; result is unchanged.
  - Else if dp_ready: result <= dp_result, go to DONE. acc/arg/count are not updated that cycle.
  - Otherwise: acc <= dp_n_acc, arg_0 <= dp_n_arg_0, arg_1 <= dp_n_arg_1, and count <= count+1, saturating at MAX_COUNT.
- DONE:
  - ready = 1 for exactly this cycle; valid is ignored.
  - Always go to IDLE next cycle, including when flush is high; ready still pulses in that case.
- Back-to-back operations: an op presented on the cycle after DONE is accepted by IDLE. Minimum latency from accept to ready is 2 cycles (dp_ready at count 0).
- Priority: flush beats valid in every state. flush and valid together in IDLE: stay in IDLE.
- Registered signals: ready and busy are decoded from the state register (glitch-free). dp_valid = (state == RUN).
- Count saturation: count never wraps. At MAX_COUNT it holds while dp_ready is low.
- Reset mid-operation: asynchronous return to IDLE with all registers cleared; no ready pulse.

Optional Feature:
- Macro: XC_MALU_SEQ_TIMEOUT_EN.
- When defined:
  - In RUN with count == MAX_COUNT && !dp_ready: go to DONE, set result = 64'hFFFF_FFFF_FFFF_FFFF and set timeout = 1.
  - timeout is sticky until reset or the next accept.
- When undefined:
  - The timeout port and its logic are absent.
  - RUN waits indefinitely, with count saturated.

Decomposition:
- Shared package xc_malu_pkg holds:
  - state encoding constants: SEQ_IDLE = 2'd0, SEQ_RUN = 2'd1, SEQ_DONE = 2'd2
  - COUNT_W and MAX_COUNT defaults
  - a 64-bit all-ones error constant
- No sub-module. The FSM and the register file are a single block of about 150–200 lines.

Test Plan (bench uses a stub datapath: dp_ready when count == N; next values are acc+1, arg_0 shifted right by 1, arg_1+2; dp_result = {32'h0, rs1+rs2}):
- Basic op, N = 5, rs1 = 7, rs2 = 6:
  - ready pulses exactly 7 cycles after the accept edge
  - result = 64'd13, acc = 5, count = 5, arg_1 = 10
- Back-to-back ops:
  - Second valid presented on the cycle after DONE: accepted immediately, each result correct.
  - ready never high on two consecutive cycles.
- Abort cases:
  - flush at count = 2 with N = 5: IDLE next cycle; no ready; result keeps its previous value.
  - valid dropped mid-RUN: same behaviour as flush.
- Immediate completion, N = 0: ready 2 cycles after accept; acc stays 0.
- Reset mid-RUN, resetn low at count = 3 for a partial cycle: all outputs are 0 immediately (asynchronous), state is IDLE.
- Timeout, with XC_MALU_SEQ_TIMEOUT_EN and N = 100:
  - count saturates at 63
  - next cycle: ready = 1, result = all-ones, timeout = 1
  - timeout clears on the next accept
- Without XC_MALU_SEQ_TIMEOUT_EN and N = 100: count holds at 63 and ready stays low until flush.
